// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the default operand width.
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage : serial_add_pkg

// File: rtl/fulladder.sv
// One-bit full adder; the only arithmetic element in the serial datapath.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   logic half_sum;

   assign half_sum = a ^ b;
   assign sum      = half_sum ^ cin;
   assign carry    = (a & b) | (cin & half_sum);

endmodule : fulladder

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clk
// through a single full adder, sequenced by a three-state FSM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; operands captured on the accepting edge
//   ADD     | one full-adder step per cycle, WIDTH cycles in total
//   DONE    | result registers valid, done pulses for this single cycle
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_sum;
   logic             fa_carry;

   fulladder u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .cin   (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_ADD;
            end
         end

         ST_ADD: begin
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
            s_sr_d              = s_sr_q >> 1;
            s_sr_d[WIDTH-1]     = fa_sum;
            a_sr_d              = a_sr_q >> 1;
            b_sr_d              = b_sr_q >> 1;
            carry_d             = fa_carry;
            cnt_d               = cnt_q + CW'(1);
            busy_d              = 1'b1;
            if (cnt_q == CNT_LAST) begin
               sum_d   = s_sr_d;
               cout_d  = fa_carry;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start1;
   logic [0:0] a1, b1;
   logic       cin1;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int checks;
   int failures;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue one WIDTH=8 operation; operands are inverted right after acceptance.
   // Returns done latency (-1 on timeout), busy-low cycles and result-hold violations.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      output int lat, output int busy_bad, output int hold_bad);
      logic [7:0] s0;
      logic       c0;
      s0 = sum8;
      c0 = cout8;
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      cyc();
      start8 = 1'b0;
      a8 = ~ta; b8 = ~tb; cin8 = ~tc;
      lat = -1; busy_bad = 0; hold_bad = 0;
      for (int t = 1; t <= 20 && lat < 0; t++) begin
         if (busy8 !== 1'b1) busy_bad++;
         if (done8 === 1'b1) lat = t;
         else begin
            if (sum8 !== s0 || cout8 !== c0) hold_bad++;
            cyc();
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      cyc(); cyc();
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
      checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done8 got=%b exp=0", done8); end
      checks++; if (sum8 !== 8'h00) begin failures++; $display("FAIL reset_sum8 got=%h exp=00", sum8); end
      checks++; if (cout8 !== 1'b0) begin failures++; $display("FAIL reset_cout8 got=%b exp=0", cout8); end
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
         failures++; $display("FAIL reset_w1 got=%b%b%b%b exp=0000", busy1, done1, sum1, cout1);
      end
      #3 rst_n = 1'b1;
      cyc(); cyc();
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL idle_no_start busy8 got=%b exp=0", busy8); end
   endtask

   task automatic test_zero();
      int lat, bb, hb;
      op8(8'h00, 8'h00, 1'b0, lat, bb, hb);
      checks++; if (lat !== 9) begin failures++; $display("FAIL zero_latency got=%0d exp=9", lat); end
      checks++; if (bb !== 0) begin failures++; $display("FAIL zero_busy_low_cycles got=%0d exp=0", bb); end
      checks++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
         failures++; $display("FAIL zero_result got=%b_%h exp=0_00", cout8, sum8);
      end
      cyc();
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b exp=0", busy8); end
      checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL zero_done_width got=%b exp=0", done8); end
   endtask

   task automatic test_carry();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic       vc [3];
      logic [7:0] es [3];
      logic       ec [3];
      int lat, bb, hb;
      va[0] = 8'h3C; vb[0] = 8'h0F; vc[0] = 1'b1; es[0] = 8'h4C; ec[0] = 1'b0;
      va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0; es[1] = 8'h00; ec[1] = 1'b1;
      va[2] = 8'hA5; vb[2] = 8'h5A; vc[2] = 1'b1; es[2] = 8'h00; ec[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op8(va[i], vb[i], vc[i], lat, bb, hb);
         checks++; if (lat !== 9) begin failures++; $display("FAIL carry%0d_latency got=%0d exp=9", i, lat); end
         checks++; if (hb !== 0) begin failures++; $display("FAIL carry%0d_hold got=%0d exp=0", i, hb); end
         checks++; if (sum8 !== es[i] || cout8 !== ec[i]) begin
            failures++; $display("FAIL carry%0d_result got=%b_%h exp=%b_%h", i, cout8, sum8, ec[i], es[i]);
         end
         cyc(); cyc(); cyc();
         checks++; if (sum8 !== es[i] || cout8 !== ec[i]) begin
            failures++; $display("FAIL carry%0d_held got=%b_%h exp=%b_%h", i, cout8, sum8, ec[i], es[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ndone, bad_pos, bad_res;
      ndone = 0; bad_pos = 0; bad_res = 0;
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      cyc();
      for (int t = 1; t <= 30; t++) begin
         if (done8 === 1'b1) begin
            ndone++;
            if (t % 10 != 9) bad_pos++;
            if (sum8 !== 8'h46 || cout8 !== 1'b0) bad_res++;
         end
         if (t % 10 >= 1 && t % 10 <= 7) begin
            a8 = 8'hFF; b8 = 8'hEE; cin8 = 1'b1;
         end else begin
            a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
         end
         if (t == 30) start8 = 1'b0;
         cyc();
      end
      checks++; if (ndone !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
      checks++; if (bad_pos !== 0) begin failures++; $display("FAIL b2b_done_spacing got=%0d exp=0", bad_pos); end
      checks++; if (bad_res !== 0) begin failures++; $display("FAIL b2b_result got=%0d exp=0", bad_res); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", busy8); end
   endtask

   task automatic test_reset_mid();
      int lat, bb, hb, nd;
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      cyc();
      start8 = 1'b0;
      cyc(); cyc(); cyc();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
      checks++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
         failures++; $display("FAIL midrst_result got=%b_%h exp=0_00", cout8, sum8);
      end
      #3 rst_n = 1'b1;
      cyc();
      nd = 0;
      for (int t = 0; t < 15; t++) begin
         if (done8 === 1'b1) nd++;
         cyc();
      end
      checks++; if (nd !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", nd); end
      op8(8'h7F, 8'h01, 1'b0, lat, bb, hb);
      checks++; if (lat !== 9) begin failures++; $display("FAIL midrst_restart_latency got=%0d exp=9", lat); end
      checks++; if (sum8 !== 8'h80 || cout8 !== 1'b0) begin
         failures++; $display("FAIL midrst_restart_result got=%b_%h exp=0_80", cout8, sum8);
      end
      cyc();
   endtask

   task automatic test_width1();
      logic [7:0] es, ec;
      logic [2:0] v;
      int lat;
      es = 8'b1001_0110;   // indexed by {a,b,cin}
      ec = 8'b1110_1000;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
         cyc();
         start1 = 1'b0;
         a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
         lat = -1;
         for (int t = 1; t <= 6 && lat < 0; t++) begin
            if (done1 === 1'b1) lat = t;
            else cyc();
         end
         checks++; if (lat !== 2) begin failures++; $display("FAIL w1_%0d_latency got=%0d exp=2", i, lat); end
         checks++; if (sum1 !== es[i]) begin failures++; $display("FAIL w1_%0d_sum got=%b exp=%b", i, sum1, es[i]); end
         checks++; if (cout1 !== ec[i]) begin failures++; $display("FAIL w1_%0d_cout got=%b exp=%b", i, cout1, ec[i]); end
         cyc();
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_zero();
      test_carry();
      test_back_to_back();
      test_reset_mid();
      test_width1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_add_ctrl
